// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit order and
// active-high glyph patterns for the sixteen hex digits.
package sevenseg_pkg;

  localparam int SEG_A_BIT = 0;
  localparam int SEG_B_BIT = 1;
  localparam int SEG_C_BIT = 2;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 4;
  localparam int SEG_F_BIT = 5;
  localparam int SEG_G_BIT = 6;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/sevenseg_scan_driver_if.sv
// Datapath-side inputs and pin-side outputs of the scan driver, bundled so the
// producer (master) and the driver (slave) see complementary directions.
interface sevenseg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    lzb_en;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic                    frame_done;

  modport master (
    output en, load, value, dp_in, lzb_en,
    input  seg, dp, dig_sel, frame_done
  );

  modport slave (
    input  en, load, value, dp_in, lzb_en,
    output seg, dp, dig_sel, frame_done
  );

endinterface

// File: rtl/sevenseg_hex_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
module sevenseg_hex_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nibble)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed 7-segment scanner with per-slot blanking, leading-zero
// suppression and a shadow register that only changes at frame boundaries.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input logic                 clk,
  input logic                 rst,
  sevenseg_scan_driver_if.slave bus
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [6:0]            SEG_POL = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_POL  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] DIG_POL = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_stage_val;
  logic [NUM_DIGITS-1:0]   r_stage_dp;
  logic                    r_pend;
  logic [4*NUM_DIGITS-1:0] r_shadow_val;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_dig_sel;
  logic                    r_frame_done;

  logic                    w_wrap;
  logic                    w_boundary;
  logic [3:0]              w_nibble;
  logic [6:0]              w_dec_seg;
  logic [NUM_DIGITS-1:0]   w_lead_zero;
  logic                    w_zero_run;
  logic                    w_blank_digit;
  logic [6:0]              w_seg_act;
  logic                    w_dp_act;
  logic [NUM_DIGITS-1:0]   w_dig_act;

  assign w_wrap     = (r_presc == PW'(CLK_DIV - 1));
  assign w_boundary = w_wrap && (r_idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_wrap) begin
      r_presc <= '0;
      r_idx   <= w_boundary ? '0 : r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // A load on the boundary cycle bypasses staging so it is never a frame late.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage_val  <= '0;
      r_stage_dp   <= '0;
      r_pend       <= 1'b0;
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
    end else begin
      if (bus.load) begin
        r_stage_val <= bus.value;
        r_stage_dp  <= bus.dp_in;
      end
      if (w_boundary) begin
        r_pend <= 1'b0;
        if (bus.load) begin
          r_shadow_val <= bus.value;
          r_shadow_dp  <= bus.dp_in;
        end else if (r_pend) begin
          r_shadow_val <= r_stage_val;
          r_shadow_dp  <= r_stage_dp;
        end
      end else if (bus.load) begin
        r_pend <= 1'b1;
      end
    end
  end

  assign w_nibble = r_shadow_val[r_idx*4 +: 4];

  sevenseg_hex_decode u_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_dec_seg)
  );

  // w_lead_zero[i] is set when nibble i and every nibble above it are zero.
  always_comb begin
    w_zero_run  = 1'b1;
    w_lead_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_run     = w_zero_run && (r_shadow_val[4*i +: 4] == 4'h0);
      w_lead_zero[i] = w_zero_run;
    end
  end

  assign w_blank_digit = bus.lzb_en && (r_idx != '0) && w_lead_zero[r_idx];

  // Everything stays dark during the anti-ghost window at the start of a slot.
  always_comb begin
    w_seg_act = SEG_BLANK;
    w_dp_act  = 1'b0;
    w_dig_act = '0;
    if (bus.en && (r_presc >= PW'(BLANK_CYCLES))) begin
      w_dig_act[r_idx] = 1'b1;
      w_dp_act         = r_shadow_dp[r_idx];
      w_seg_act        = w_blank_digit ? SEG_BLANK : w_dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg        <= SEG_POL;
      r_dp         <= DP_POL;
      r_dig_sel    <= DIG_POL;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_act ^ SEG_POL;
      r_dp         <= w_dp_act ^ DP_POL;
      r_dig_sel    <= w_dig_act ^ DIG_POL;
      r_frame_done <= w_boundary;
    end
  end

  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.dig_sel    = r_dig_sel;
  assign bus.frame_done = r_frame_done;

endmodule
